id_stage: RTL and testbench

Instruction-decode/issue stage of the in-order RV32I core. It sits between fetch and execute and drives the read ports of the register file. It accepts one fetched instruction per cycle through a valid/ready handshake and extracts register indices and the sign-extended immediate. It keeps a 32-entry busy scoreboard for RAW/WAW interlocks and holds the operand-complete instruction in an output register for the execute stage.

---
 rtl/id_stage.sv | 174 +++++++++++++++++
 tb/tb_id_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I decode/issue stage between fetch and execute.
// Latency: one cycle from accept to ex_valid; sustains one instruction per cycle with no hazard.
// Backpressure: if_ready drops on a RAW/WAW hazard, flush, rdy low, reset, or a held output that execute has not taken.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   rdy               global enable; low freezes every register
//   if_valid/if_ready fetch handshake carrying if_pc / if_inst
//   r1_*/r2_*         register-file read ports (the file bypasses same-cycle writes)
//   clr_en/clr_addr   writeback retire; clears one busy bit
//   flush             kills the instruction held for execute
//   ex_*              issued instruction register with ex_valid/ex_ready handshake
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  output logic        r1_en,
  output logic        r2_en,
  output logic [4:0]  r1_addr,
  output logic [4:0]  r2_addr,
  input  logic [31:0] r1_data,
  input  logic [31:0] r2_data,
  input  logic        clr_en,
  input  logic [4:0]  clr_addr,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [4:0]  ex_rd,
  output logic        ex_wr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        uses_rs1, uses_rs2, wr_class, writes_rd;

  // Bit 0 is never written to 1, so x0 can never look busy.
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  logic hazard, accept, handoff;
  logic rs1_hz, rs2_hz, rd_hz;

  assign opcode = if_inst[6:0];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];
  assign rd     = if_inst[11:7];

  // Opcode classification and immediate formation.
  always_comb begin
    imm      = 32'd0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wr_class = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm      = {{20{if_inst[31]}}, if_inst[31:20]};
        uses_rs1 = 1'b1;
        wr_class = 1'b1;
      end
      OP_STORE: begin
        imm      = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25],
                    if_inst[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm      = {if_inst[31:12], 12'd0};
        wr_class = 1'b1;
      end
      OP_JAL: begin
        imm      = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20],
                    if_inst[30:21], 1'b0};
        wr_class = 1'b1;
      end
      OP_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        wr_class = 1'b1;
      end
      default: begin
        imm = 32'd0;
      end
    endcase
  end

  assign writes_rd = wr_class & (rd != 5'd0);

  assign r1_addr = rs1;
  assign r2_addr = rs2;
  assign r1_en   = if_valid & uses_rs1;
  assign r2_en   = if_valid & uses_rs2;

  // A register is pending if its busy bit survives this cycle's clear, or if
  // the instruction sitting in the output register is about to claim it.
  assign rs1_hz = uses_rs1 &
                  ((busy[rs1] & ~(clr_en & (clr_addr == rs1))) |
                   (ex_valid & ex_wr & (ex_rd == rs1)));
  assign rs2_hz = uses_rs2 &
                  ((busy[rs2] & ~(clr_en & (clr_addr == rs2))) |
                   (ex_valid & ex_wr & (ex_rd == rs2)));
  assign rd_hz  = writes_rd &
                  ((busy[rd] & ~(clr_en & (clr_addr == rd))) |
                   (ex_valid & ex_wr & (ex_rd == rd)));
  assign hazard = rs1_hz | rs2_hz | rd_hz;

  assign if_ready = ~rst & rdy & ~flush & ~hazard & (~ex_valid | ex_ready);
  assign accept   = if_valid & if_ready;
  // A flush discards the handoff, so the killed instruction claims no register.
  assign handoff  = ex_valid & ex_ready & rdy & ~flush;

  // Clear first, then set, so a same-cycle set of the same bit wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (handoff && ex_wr) busy_nxt[ex_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 32'd0;
      ex_valid   <= 1'b0;
      ex_pc      <= 32'd0;
      ex_inst    <= 32'd0;
      ex_imm     <= 32'd0;
      ex_rs1_val <= 32'd0;
      ex_rs2_val <= 32'd0;
      ex_rd      <= 5'd0;
      ex_wr      <= 1'b0;
    end else if (rdy) begin
      busy <= busy_nxt;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid   <= 1'b1;
        ex_pc      <= if_pc;
        ex_inst    <= if_inst;
        ex_imm     <= imm;
        ex_rs1_val <= uses_rs1 ? r1_data : 32'd0;
        ex_rs2_val <= uses_rs2 ? r2_data : 32'd0;
        ex_rd      <= rd;
        ex_wr      <= writes_rd;
      end else if (handoff) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed vectors for decode, hazards,
// stall/flush, rdy freeze and mid-stall reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        r1_en, r2_en;
  logic [4:0]  r1_addr, r2_addr;
  logic [31:0] r1_data, r2_data;
  logic        clr_en;
  logic [4:0]  clr_addr;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_inst, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_wr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .r1_en(r1_en), .r2_en(r2_en), .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_data(r1_data), .r2_data(r2_data),
    .clr_en(clr_en), .clr_addr(clr_addr), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_imm(ex_imm),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .ex_wr(ex_wr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_valid = 1'b0; if_pc = 32'd0; if_inst = 32'd0;
    r1_data = 32'd0; r2_data = 32'd0; clr_en = 1'b0; clr_addr = 5'd0;
    flush = 1'b0; ex_ready = 1'b0;
    settle();
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Idle after reset.
    settle();
    chk("idle_if_ready", {31'd0, if_ready}, 32'd1);
    chk("idle_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("idle_busy",     dut.busy, 32'd0);
    chk("idle_ex_pc",    ex_pc, 32'd0);
    chk("idle_ex_imm",   ex_imm, 32'd0);
    chk("idle_ex_rd",    {27'd0, ex_rd}, 32'd0);

    // ADDI x5,x0,-1
    if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'hFFF00293; ex_ready = 1'b1;
    settle();
    chk("addi_if_ready", {31'd0, if_ready}, 32'd1);
    chk("addi_ren", {30'd0, r1_en, r2_en}, 32'd2);
    cyc();
    chk("addi_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("addi_ex_imm",   ex_imm, 32'hFFFFFFFF);
    chk("addi_ex_rd",    {27'd0, ex_rd}, 32'd5);
    chk("addi_ex_wr",    {31'd0, ex_wr}, 32'd1);
    chk("addi_ex_pc",    ex_pc, 32'h100);

    // ADD x6,x5,x5: stalls behind x5 until writeback clears it.
    if_pc = 32'h104; if_inst = 32'h00528333;
    settle();
    chk("add_hz_ex", {31'd0, if_ready}, 32'd0);
    cyc();
    chk("add_busy5", dut.busy, 32'h20);
    chk("add_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("add_hz_busy", {31'd0, if_ready}, 32'd0);
    cyc();
    chk("add_hz_busy2", {31'd0, if_ready}, 32'd0);
    clr_en = 1'b1; clr_addr = 5'd5; r1_data = 32'h12345678; r2_data = 32'h12345678;
    settle();
    chk("add_clr_ready", {31'd0, if_ready}, 32'd1);
    cyc();
    clr_en = 1'b0; r1_data = 32'd0; r2_data = 32'd0;
    chk("add_rs1", ex_rs1_val, 32'h12345678);
    chk("add_rs2", ex_rs2_val, 32'h12345678);
    chk("add_rd",  {27'd0, ex_rd}, 32'd6);
    chk("add_busy_clr", dut.busy, 32'd0);

    // BEQ x0,x0,-4096
    if_pc = 32'h108; if_inst = 32'h80000063;
    cyc();
    chk("beq_imm", ex_imm, 32'hFFFFF000);
    chk("beq_wr",  {31'd0, ex_wr}, 32'd0);
    chk("beq_busy6", dut.busy, 32'h40);

    // JAL x1,+2
    if_pc = 32'h10C; if_inst = 32'h002000EF;
    cyc();
    chk("jal_imm", ex_imm, 32'd2);
    chk("jal_rd",  {27'd0, ex_rd}, 32'd1);
    chk("jal_wr",  {31'd0, ex_wr}, 32'd1);
    chk("jal_busy", dut.busy, 32'h40);

    // Execute stalls for three cycles with ADDI x7,x0,3 waiting.
    ex_ready = 1'b0; if_pc = 32'h110; if_inst = 32'h00300393;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_if_ready", {31'd0, if_ready}, 32'd0);
      cyc();
      chk("stall_ex_imm", ex_imm, 32'd2);
      chk("stall_ex_pc",  ex_pc, 32'h10C);
    end
    // Flush with ex_ready high: the handoff is discarded.
    flush = 1'b1; ex_ready = 1'b1;
    settle();
    chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
    cyc();
    flush = 1'b0; if_valid = 1'b0; clr_en = 1'b1; clr_addr = 5'd6;
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_busy", dut.busy, 32'h40);
    cyc();
    clr_en = 1'b0;
    chk("clr6_busy", dut.busy, 32'd0);

    // NOP stream never stalls.
    if_valid = 1'b1; if_inst = 32'h00000013;
    for (int i = 0; i < 4; i++) begin
      if_pc = 32'h200 + 32'(i * 4);
      settle();
      chk("nop_if_ready", {31'd0, if_ready}, 32'd1);
      cyc();
      chk("nop_ex_wr", {31'd0, ex_wr}, 32'd0);
      chk("nop_ex_pc", ex_pc, 32'h200 + 32'(i * 4));
      chk("nop_busy", dut.busy, 32'd0);
    end

    // rdy low freezes everything; LUI x3,0xABCDE waits.
    rdy = 1'b0; if_pc = 32'h300; if_inst = 32'hABCDE1B7;
    settle();
    chk("rdy_if_ready", {31'd0, if_ready}, 32'd0);
    chk("lui_r1_en", {31'd0, r1_en}, 32'd0);
    cyc();
    chk("rdy_ex_pc", ex_pc, 32'h20C);
    chk("rdy_ex_valid", {31'd0, ex_valid}, 32'd1);
    rdy = 1'b1;
    cyc();
    chk("lui_imm", ex_imm, 32'hABCDE000);
    chk("lui_rd", {27'd0, ex_rd}, 32'd3);
    if_valid = 1'b0;
    cyc();
    chk("lui_busy3", dut.busy, 32'h08);

    // SW x2,-8(x1): stall it in the output register, then reset mid-cycle.
    if_valid = 1'b1; if_pc = 32'h400; if_inst = 32'hFE20AC23;
    cyc();
    chk("sw_imm", ex_imm, 32'hFFFFFFF8);
    ex_ready = 1'b0; if_valid = 1'b0;
    cyc();
    #2;
    rst = 1'b1;
    settle();
    chk("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("mid_rst_busy", dut.busy, 32'd0);
    chk("mid_rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("mid_rst_ex_imm", ex_imm, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
